mantis_synth_regs: RTL

MANTIS_SYNTH_REGS -- requirements
Module: mantis_synth_regs

---
 rtl/mantis_synth_regs.sv | 109 ++++++++++
 1 files changed

// File: rtl/mantis_synth_regs.sv
// AXI4-Lite register block for the synth voice: four shadow registers written over AXI,
// copied to the live outputs only at audio sample boundaries so a voice never sees a half-updated set.
module mantis_synth_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              sample_tick,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     phase_inc_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     amplitude_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     wave_sel_o,
    output logic                              reg_update
);
    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] shadow [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] live   [4];
    logic [3:0] pending;
    logic [3:0] wr_hit;
    logic [3:0] xfer;
    logic       aw_w_ready;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] wr_idx;
    logic [1:0] rd_idx;
    logic       unused_addr_bits;

    assign wr_idx = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
    assign rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
    assign unused_addr_bits = ^{s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-3:0], s00_axi_araddr[C_S_AXI_ADDR_WIDTH-3:0]};

    assign s00_axi_awready = aw_w_ready;
    assign s00_axi_wready  = aw_w_ready;
    assign s00_axi_bresp   = '0;
    assign s00_axi_rresp   = '0;
    assign wr_en = aw_w_ready && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_en = s00_axi_arready && s00_axi_arvalid;

    assign ctrl_o      = live[0];
    assign phase_inc_o = live[1];
    assign amplitude_o = live[2];
    assign wave_sel_o  = live[3];

    // A register being written on the tick edge must wait for the next tick.
    always_comb begin
        wr_hit = '0;
        if (wr_en) wr_hit[wr_idx] = 1'b1;
        xfer = sample_tick ? (pending & ~wr_hit) : '0;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_w_ready      <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            pending         <= '0;
            reg_update      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            aw_w_ready <= !aw_w_ready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
            if (wr_en)               s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;

            s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
            if (rd_en) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= shadow[rd_idx];
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end

            if (wr_en) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (s00_axi_wstrb[b]) shadow[wr_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                end
            end

            for (int unsigned i = 0; i < 4; i++) begin
                if (xfer[i]) live[i] <= shadow[i];
            end
            pending    <= (pending & ~xfer) | wr_hit;
            reg_update <= |xfer;
        end
    end
endmodule
